uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, which sets the FIFO entry count and SHALL be a power of two, 2..256.
REQ-002 The block SHALL have parameter DATA_W, default 8, which sets the byte width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 i_reset_n  input  1  asynchronous active-low reset.
REQ-006 i_data  input  DATA_W  received byte from the upstream UART receiver.
REQ-007 i_data_valid  input  1  single-cycle strobe; i_data is valid this cycle.
REQ-008 i_rd_en  input  1  consumer pop request for the head entry.
REQ-009 i_clear_overflow  input  1  clears the sticky overflow flag.
REQ-010 o_data  output  DATA_W  head entry, first-word-fall-through; 0 when empty.
REQ-011 o_data_valid  output  1  high when the FIFO is not empty.
REQ-012 o_count  output  clog2(DEPTH)+1  number of stored entries.
REQ-013 o_full  output  1  o_count == DEPTH.
REQ-014 o_empty  output  1  o_count == 0.
REQ-015 o_overflow  output  1  sticky flag: a byte was dropped.

Function
REQ-016 Write: on an edge with i_data_valid=1 and (not full, or a pop accepted on the same edge), the block SHALL store i_data at the write pointer and advance the pointer.
REQ-017 Pop: on an edge with i_rd_en=1 and not empty, the block SHALL advance the read pointer.
REQ-018 i_rd_en while empty SHALL be ignored: no state change and no error flag.
REQ-019 Latency: a byte written at edge N SHALL appear on o_data with o_data_valid=1 in the cycle after edge N when the FIFO was empty.
REQ-020 o_data, o_data_valid, o_full, o_empty and o_count SHALL be driven from registered state only; no combinational path from i_* to o_*.
REQ-021 Write and pop on the same edge SHALL leave o_count unchanged. This applies when full and when holding one entry; in the one-entry case the new byte becomes head.
REQ-022 Write while full without a pop SHALL drop the byte, leave all entries unchanged, and set o_overflow on that edge.
REQ-023 When DEPTH is a power of two, pointers SHALL wrap modulo DEPTH with no gap.
REQ-024 o_count SHALL be arithmetic modulo nothing: it never exceeds DEPTH and never underflows below 0.
REQ-025 i_clear_overflow=1 SHALL clear o_overflow on the next edge. If an overflow drop occurs on the same edge, set SHALL win.
REQ-026 An i_data_valid held high for several cycles SHALL be treated as one write per cycle; the block does not edge-detect.

Reset
REQ-027 Asserting i_reset_n low SHALL immediately clear both pointers, o_count and o_overflow, and force o_data=0, o_data_valid=0, o_empty=1, o_full=0.
REQ-028 Reset mid-operation SHALL discard all stored bytes. Storage array contents need not be cleared, but SHALL never be visible while empty.
REQ-029 The first write SHALL be accepted on the first rising edge after i_reset_n deasserts.

Structure
REQ-030 UART_DATA_W (8) and UART_RX_FIFO_DEPTH (16) SHALL live in the shared package uart_pkg, which the receiver also imports.
REQ-031 The storage array SHALL be a sub-module uart_fifo_mem with one synchronous write port and one asynchronous read port. Pointer, count and flag logic SHALL stay in uart_rx_fifo.

Verification
REQ-032 Fill/drain: write 0x00..0x0F, one per 2 cycles -> o_full=1, o_count=16; then pop 16 times -> o_data 0x00..0x0F in order, then o_empty=1.
REQ-033 Overflow: with the FIFO full, write 0xAA -> o_overflow=1, o_count=16, head still 0x00; assert i_clear_overflow -> o_overflow=0 next cycle.
REQ-034 Simultaneous write and pop:
  - when full: write 0x55 with i_rd_en=1 -> o_count stays 16, no overflow, 0x55 popped last;
  - when one entry is held: head becomes 0x55.
REQ-035 Empty pop: i_rd_en=1 for 5 cycles while empty -> o_count=0, o_data=0, flags unchanged.
REQ-036 Wrap: run 40 write/pop pairs of pattern i*3 mod 256, keeping 1..3 entries stored -> output order matches input order across the pointer wrap.
REQ-037 Async reset: with 7 entries and o_overflow=1, pulse i_reset_n low mid-cycle -> outputs reach reset values before the next edge; the next write is 0x3C -> o_data=0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART constants, imported by the receiver and by its RX FIFO.
//   UART_DATA_W         : width of one received character
//   UART_RX_FIFO_DEPTH  : default entry count of the RX FIFO
//   is_valid_depth()    : true for power-of-two depths in 2..256
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    function automatic bit is_valid_depth(input int depth);
        return (depth >= 2) && (depth <= 256) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// Storage array for the UART RX FIFO: one synchronous write port and one
// asynchronous read port. Contents are not reset; the owning FIFO masks the
// read data whenever it holds no entries.
// Ports:
//   clk      : system clock, writes on rising edge
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational from the array)
// ---------------------------------------------------------------------------
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through FIFO buffering bytes from the UART receiver.
// Bytes arriving while full (with no simultaneous pop) are dropped and
// latch a sticky overflow flag.
// Ports:
//   clk              : system clock
//   i_reset_n        : asynchronous active-low reset
//   i_data           : received byte
//   i_data_valid     : one write per cycle while high
//   i_rd_en          : pop the head entry (ignored while empty)
//   i_clear_overflow : clear the sticky overflow flag
//   o_data           : head entry, 0 while empty
//   o_data_valid     : FIFO not empty
//   o_count          : number of stored entries (0..DEPTH)
//   o_full / o_empty : count == DEPTH / count == 0
//   o_overflow       : sticky, a byte was dropped
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                    clk,
    input  logic                    i_reset_n,
    input  logic [DATA_W-1:0]       i_data,
    input  logic                    i_data_valid,
    input  logic                    i_rd_en,
    input  logic                    i_clear_overflow,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_data_valid,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if (!is_valid_depth(DEPTH)) begin : g_depth_check
        $error("uart_rx_fifo: DEPTH must be a power of two in 2..256");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              drop;
    logic [DATA_W-1:0] head;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A pop on the same edge frees the slot being written, so a full FIFO
    // can still accept a byte when the consumer reads at the same time.
    assign pop  = i_rd_en && !empty;
    assign push = i_data_valid && (!full || pop);
    assign drop = i_data_valid && full && !pop;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            // A drop on the same edge as a clear request keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (i_clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (push),
        .i_waddr (wr_ptr),
        .i_wdata (i_data),
        .i_raddr (rd_ptr),
        .o_rdata (head)
    );

    // Stale array contents are never exposed: the head is masked while empty,
    // and since count resets asynchronously the mask applies during reset too.
    assign o_data       = empty ? '0 : head;
    assign o_data_valid = !empty;
    assign o_count      = count;
    assign o_full       = full;
    assign o_empty      = empty;
    assign o_overflow   = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Bench for uart_rx_fifo (DEPTH 16, 8-bit data). A queue-based reference
// model tracks stored bytes and the overflow flag.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              i_reset_n;
    logic [DATA_W-1:0] i_data;
    logic              i_data_valid;
    logic              i_rd_en;
    logic              i_clear_overflow;
    logic [DATA_W-1:0] o_data;
    logic              o_data_valid;
    logic [4:0]        o_count;
    logic              o_full;
    logic              o_empty;
    logic              o_overflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk              (clk),
        .i_reset_n        (i_reset_n),
        .i_data           (i_data),
        .i_data_valid     (i_data_valid),
        .i_rd_en          (i_rd_en),
        .i_clear_overflow (i_clear_overflow),
        .o_data           (o_data),
        .o_data_valid     (o_data_valid),
        .o_count          (o_count),
        .o_full           (o_full),
        .o_empty          (o_empty),
        .o_overflow       (o_overflow)
    );

    function automatic logic [7:0] exp_head();
        return (mq.size() > 0) ? mq[0] : 8'h00;
    endfunction

    // Drive one cycle from a falling edge, update the reference model at the
    // rising edge, return on the next falling edge with inputs idle.
    task automatic cycle(input logic v, input logic [7:0] d, input logic rd, input logic clr);
        bit p;
        bit w;
        i_data_valid     = v;
        i_data           = d;
        i_rd_en          = rd;
        i_clear_overflow = clr;
        @(posedge clk);
        p = rd && (mq.size() > 0);
        w = v && ((mq.size() < DEPTH) || p);
        if (p) void'(mq.pop_front());
        if (w) mq.push_back(d);
        if (v && !w) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(negedge clk);
        i_data_valid     = 1'b0;
        i_rd_en          = 1'b0;
        i_clear_overflow = 1'b0;
        i_data           = '0;
    endtask

    task automatic test_reset();
        i_reset_n        = 1'b0;
        i_data           = '0;
        i_data_valid     = 1'b0;
        i_rd_en          = 1'b0;
        i_clear_overflow = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_count !== 5'd0 || o_empty !== 1'b1 || o_full !== 1'b0 ||
            o_data_valid !== 1'b0 || o_data !== 8'h00 || o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state count=%0d empty=%b full=%b valid=%b data=%h ovf=%b exp 0/1/0/0/00/0",
                     o_count, o_empty, o_full, o_data_valid, o_data, o_overflow);
        end
        i_reset_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        // First write lands on the first edge after reset release.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 0) begin
                checks++;
                if (o_count !== 5'd1 || o_data_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL first_write count=%0d valid=%b exp 1/1", o_count, o_data_valid);
                end
            end
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
        end
        checks++;
        if (o_full !== 1'b1 || o_count !== 5'd16) begin
            failures++;
            $display("FAIL fill_full full=%b count=%0d exp 1/16", o_full, o_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (o_data !== 8'(i)) begin
                failures++;
                $display("FAIL drain_order idx=%0d got=%h exp=%h", i, o_data, 8'(i));
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if (o_empty !== 1'b1 || o_count !== 5'd0 || o_data !== 8'h00) begin
            failures++;
            $display("FAIL drain_empty empty=%b count=%0d data=%h exp 1/0/00", o_empty, o_count, o_data);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        checks++;
        if (o_overflow !== 1'b1 || o_count !== 5'd16 || o_data !== 8'h00) begin
            failures++;
            $display("FAIL overflow_set ovf=%b count=%0d head=%h exp 1/16/00", o_overflow, o_count, o_data);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear ovf=%b exp 0", o_overflow);
        end
        // Drop and clear on the same edge: set must win.
        cycle(1'b1, 8'hBB, 1'b0, 1'b1);
        checks++;
        if (o_overflow !== 1'b1 || o_data !== 8'h00) begin
            failures++;
            $display("FAIL overflow_set_wins ovf=%b head=%h exp 1/00", o_overflow, o_data);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (o_overflow !== m_ovf || o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_reclear ovf=%b exp 0", o_overflow);
        end
    endtask

    task automatic test_simul_full();
        // FIFO holds 0x00..0x0F from the previous scenario.
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if (o_count !== 5'd16 || o_overflow !== 1'b0 || o_data !== 8'h01) begin
            failures++;
            $display("FAIL simul_full count=%0d ovf=%b head=%h exp 16/0/01", o_count, o_overflow, o_data);
        end
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (o_data !== exp_head()) begin
                failures++;
                $display("FAIL simul_full_order idx=%0d got=%h exp=%h", k, o_data, exp_head());
            end
            if (k == DEPTH - 1) begin
                checks++;
                if (o_data !== 8'h55) begin
                    failures++;
                    $display("FAIL simul_full_last got=%h exp=55", o_data);
                end
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_simul_one();
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if (o_data !== 8'h55 || o_count !== 5'd1 || o_data_valid !== 1'b1) begin
            failures++;
            $display("FAIL simul_one head=%h count=%0d valid=%b exp 55/1/1", o_data, o_count, o_data_valid);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_empty_pop();
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (o_count !== 5'd0 || o_data !== 8'h00 || o_empty !== 1'b1 ||
            o_full !== 1'b0 || o_overflow !== 1'b0 || o_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_pop count=%0d data=%h empty=%b full=%b ovf=%b valid=%b exp 0/00/1/0/0/0",
                     o_count, o_data, o_empty, o_full, o_overflow, o_data_valid);
        end
    endtask

    task automatic test_wrap();
        int nxt = 0;
        int s;
        logic rd;
        for (int i = 0; i < 40; i++) begin
            s  = mq.size();
            rd = (s >= 3) ? 1'b1 : ((s == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
            if (rd) begin
                checks++;
                if (o_data !== 8'(nxt * 3)) begin
                    failures++;
                    $display("FAIL wrap_order idx=%0d got=%h exp=%h", nxt, o_data, 8'(nxt * 3));
                end
                nxt++;
            end
            cycle(1'b1, 8'(i * 3), rd, 1'b0);
            if (i == 0) begin
                checks++;
                if (o_data_valid !== 1'b1 || o_count !== 5'd1) begin
                    failures++;
                    $display("FAIL wrap_latency valid=%b count=%0d exp 1/1", o_data_valid, o_count);
                end
            end
        end
        for (int g = 0; g < 4 && nxt < 40; g++) begin
            checks++;
            if (o_data !== 8'(nxt * 3)) begin
                failures++;
                $display("FAIL wrap_tail idx=%0d got=%h exp=%h", nxt, o_data, 8'(nxt * 3));
            end
            nxt++;
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if (nxt !== 40 || o_empty !== 1'b1) begin
            failures++;
            $display("FAIL wrap_complete popped=%0d empty=%b exp 40/1", nxt, o_empty);
        end
    endtask

    task automatic test_random();
        logic v;
        logic rd;
        logic clr;
        for (int c = 0; c < 400; c++) begin
            if (c < 200) begin
                v  = ($urandom_range(0, 3) != 0);
                rd = ($urandom_range(0, 3) == 0);
            end else begin
                v  = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 3) != 0);
            end
            clr = ($urandom_range(0, 7) == 0);
            cycle(v, 8'($urandom), rd, clr);
            checks++;
            if (o_count !== 5'(mq.size()) || o_data !== exp_head() ||
                o_data_valid !== (mq.size() > 0) || o_full !== (mq.size() == DEPTH) ||
                o_empty !== (mq.size() == 0) || o_overflow !== m_ovf) begin
                failures++;
                $display("FAIL random cyc=%0d count=%0d/%0d data=%h/%h full=%b empty=%b ovf=%b/%b",
                         c, o_count, mq.size(), o_data, exp_head(), o_full, o_empty, o_overflow, m_ovf);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int g = 0; g <= DEPTH && mq.size() > 0; g++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (o_count !== 5'd7 || o_overflow !== 1'b1 || o_data !== 8'h89) begin
            failures++;
            $display("FAIL pre_reset count=%0d ovf=%b head=%h exp 7/1/89", o_count, o_overflow, o_data);
        end
        #2;
        i_reset_n = 1'b0;
        #1;
        checks++;
        if (o_count !== 5'd0 || o_empty !== 1'b1 || o_full !== 1'b0 ||
            o_data_valid !== 1'b0 || o_data !== 8'h00 || o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL async_reset count=%0d empty=%b full=%b valid=%b data=%h ovf=%b exp 0/1/0/0/00/0",
                     o_count, o_empty, o_full, o_data_valid, o_data, o_overflow);
        end
        #1;
        i_reset_n = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (o_data !== 8'h3C || o_count !== 5'd1 || o_data_valid !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_write data=%h count=%0d valid=%b exp 3C/1/1", o_data, o_count, o_data_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simul_full();
        test_simul_one();
        test_empty_pop();
        test_wrap();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
